// File: rtl/bits32_8word_c.sv
// 32-to-8 serializer: one word in via valid/ready, four bytes out on consecutive 4f edges.
// A one-word holding register lets the next word queue so back-to-back words stream gap-free.
module bits32_8word_c #(
  parameter bit         MSB_FIRST = 1'b1,
  parameter logic [7:0] IDLE_BYTE = 8'h00
) (
  input  logic        clk_4f_c,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] Data_in,
  output logic        ready_out,
  output logic        valid_out_c,
  output logic [7:0]  Data_out_c
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state;
  logic [1:0]       cnt;
  logic [3:0][7:0]  w_q;
  logic [3:0][7:0]  h_q;
  logic             hold_full;
  logic [3:0][7:0]  din_lanes;
  logic             accept;
  logic [1:0]       cnt_nxt;

  // Transmit order index -> byte lane of the packed word.
  function automatic logic [7:0] sel_byte(input logic [3:0][7:0] x, input logic [1:0] i);
    logic [1:0] lane;
    lane = MSB_FIRST ? (2'd3 - i) : i;
    return x[lane];
  endfunction

  assign din_lanes = Data_in;
  assign ready_out = ~hold_full;
  assign accept    = valid_in & ready_out;
  assign cnt_nxt   = cnt + 2'd1;

  always_ff @(posedge clk_4f_c or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cnt         <= 2'd0;
      w_q         <= '0;
      h_q         <= '0;
      hold_full   <= 1'b0;
      valid_out_c <= 1'b0;
      Data_out_c  <= IDLE_BYTE;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            w_q         <= din_lanes;
            Data_out_c  <= sel_byte(din_lanes, 2'd0);
            valid_out_c <= 1'b1;
            cnt         <= 2'd0;
            state       <= SEND;
          end else begin
            valid_out_c <= 1'b0;
            Data_out_c  <= IDLE_BYTE;
          end
        end
        SEND: begin
          if (cnt != 2'd3) begin
            Data_out_c <= sel_byte(w_q, cnt_nxt);
            cnt        <= cnt_nxt;
            if (accept) begin
              h_q       <= din_lanes;
              hold_full <= 1'b1;
            end
          end else if (hold_full) begin
            // Queued word starts right behind the last byte, no idle cycle.
            w_q        <= h_q;
            Data_out_c <= sel_byte(h_q, 2'd0);
            cnt        <= 2'd0;
            hold_full  <= 1'b0;
          end else if (accept) begin
            w_q        <= din_lanes;
            Data_out_c <= sel_byte(din_lanes, 2'd0);
            cnt        <= 2'd0;
          end else begin
            valid_out_c <= 1'b0;
            Data_out_c  <= IDLE_BYTE;
            state       <= IDLE;
          end
        end
        default: begin
          state       <= IDLE;
          valid_out_c <= 1'b0;
          Data_out_c  <= IDLE_BYTE;
        end
      endcase
    end
  end

endmodule
